ex_cycle: RTL and testbench

// - Execute stage of the 5-stage RV32I pipeline. Sits between the ID/EX register and mem_cycle.
// - Selects forwarded operands, runs the ALU, resolves branches and jumps, and owns the EX/MEM register.
// - The MEM_* outputs of this block drive the MEM_* inputs of mem_cycle directly.

---
 rtl/ex_cycle.sv | 232 +++++++++++++++++++++++
 tb/tb_ex_cycle.sv | 322 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ex_cycle.sv
// ex_cycle: execute stage of the RV32I pipeline.
// Operand forwarding, ALU, branch/jump resolution and the EX/MEM register.
// Optional RV32M multiply (ops 11..14), built only when EX_MUL_EN is defined:
// a shift-add FSM that holds EX_busy high while it iterates.
//
// Multiply FSM states
//   state  | meaning
//   S_IDLE | no multiply in flight; a presented mul op starts one
//   S_CALC | one shift-add step per clock, MUL_CYCLES steps
//   S_DONE | product ready; EX/MEM captures it when EX_stall_en=1
module ex_cycle #(
    parameter int MUL_CYCLES = 32
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        EX_stall_en,
    input  logic        EX_rst_n,
    input  logic [31:0] EX_pc,
    input  logic [31:0] EX_rs1_data,
    input  logic [31:0] EX_rs2_data,
    input  logic [31:0] EX_imm,
    input  logic [4:0]  EX_rd_addr,
    input  logic [1:0]  EX_fwd_a_sel,
    input  logic [1:0]  EX_fwd_b_sel,
    input  logic [31:0] WB_fwd_data,
    input  logic        EX_opa_sel,
    input  logic        EX_opb_sel,
    input  logic [3:0]  EX_alu_op,
    input  logic        EX_br_en,
    input  logic [2:0]  EX_br_type,
    input  logic        EX_jmp_en,
    input  logic        EX_rd_wren,
    input  logic [8:0]  EX_mem_en,
    input  logic [1:0]  EX_wb_en,
    input  logic        EX_ld_en,
    output logic [31:0] MEM_alu_data,
    output logic [31:0] MEM_rs2_data,
    output logic [31:0] MEM_pc_four,
    output logic [4:0]  MEM_rd_addr,
    output logic        MEM_rd_wren,
    output logic [8:0]  MEM_mem_en,
    output logic [1:0]  MEM_wb_en,
    output logic        MEM_ld_en,
    output logic        MEM_pc_br,
    output logic        EX_busy
);

    if (MUL_CYCLES < 1 || MUL_CYCLES > 32) begin : g_bad_mul_cycles
        $error("ex_cycle: MUL_CYCLES must be in 1..32");
    end

    logic [31:0] fwd_a, fwd_b, op_a, op_b, alu_res, ex_res;
    logic        br_taken;

    // Forwarding muxes; select 11 falls back to the register-file value
    always_comb begin
        case (EX_fwd_a_sel)
            2'b01:   fwd_a = MEM_alu_data;
            2'b10:   fwd_a = WB_fwd_data;
            default: fwd_a = EX_rs1_data;
        endcase
        case (EX_fwd_b_sel)
            2'b01:   fwd_b = MEM_alu_data;
            2'b10:   fwd_b = WB_fwd_data;
            default: fwd_b = EX_rs2_data;
        endcase
    end

    assign op_a = EX_opa_sel ? EX_pc  : fwd_a;
    assign op_b = EX_opb_sel ? EX_imm : fwd_b;

    // Single-cycle ALU; multiply ops and op 15 produce 0 here
    always_comb begin
        alu_res = '0;
        case (EX_alu_op)
            4'd0:    alu_res = op_a + op_b;
            4'd1:    alu_res = op_a - op_b;
            4'd2:    alu_res = op_a << op_b[4:0];
            4'd3:    alu_res = {31'd0, ($signed(op_a) < $signed(op_b))};
            4'd4:    alu_res = {31'd0, (op_a < op_b)};
            4'd5:    alu_res = op_a ^ op_b;
            4'd6:    alu_res = op_a >> op_b[4:0];
            4'd7:    alu_res = $unsigned($signed(op_a) >>> op_b[4:0]);
            4'd8:    alu_res = op_a | op_b;
            4'd9:    alu_res = op_a & op_b;
            4'd10:   alu_res = op_b;
            default: alu_res = '0;
        endcase
    end

    // Branch condition on the forwarded register values, not the ALU inputs
    always_comb begin
        br_taken = 1'b0;
        case (EX_br_type)
            3'b000:  br_taken = (fwd_a == fwd_b);
            3'b001:  br_taken = (fwd_a != fwd_b);
            3'b100:  br_taken = ($signed(fwd_a) <  $signed(fwd_b));
            3'b101:  br_taken = ($signed(fwd_a) >= $signed(fwd_b));
            3'b110:  br_taken = (fwd_a <  fwd_b);
            3'b111:  br_taken = (fwd_a >= fwd_b);
            default: br_taken = 1'b0;
        endcase
    end

`ifdef EX_MUL_EN
    typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} mul_state_t;

    mul_state_t  mul_state, mul_state_nxt;
    logic        mul_busy, mul_start, is_mul_op, a_neg, b_neg;
    logic        mul_neg, mul_hi;
    logic [5:0]  mul_count;
    logic [31:0] mag_a, mag_b, mul_mplr, mul_res;
    logic [63:0] mul_mcand, mul_prod, prod_fin;

    assign is_mul_op = (EX_alu_op >= 4'd11) && (EX_alu_op <= 4'd14);
    // A is signed for MUL/MULH/MULHSU, B only for MUL/MULH
    assign a_neg     = op_a[31] && (EX_alu_op != 4'd14);
    assign b_neg     = op_b[31] && ((EX_alu_op == 4'd11) || (EX_alu_op == 4'd12));
    assign mag_a     = a_neg ? (~op_a + 32'd1) : op_a;
    assign mag_b     = b_neg ? (~op_b + 32'd1) : op_b;
    assign prod_fin  = mul_neg ? (~mul_prod + 64'd1) : mul_prod;
    assign mul_res   = mul_hi ? prod_fin[63:32] : prod_fin[31:0];

    // Multiply FSM state register
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) mul_state <= S_IDLE;
        else         mul_state <= mul_state_nxt;
    end

    // Next state and busy; a flush aborts any multiply in flight
    always_comb begin
        mul_state_nxt = mul_state;
        mul_busy      = 1'b0;
        mul_start     = 1'b0;
        case (mul_state)
            S_IDLE: if (is_mul_op && EX_stall_en) begin
                mul_busy      = 1'b1;
                mul_start     = 1'b1;
                mul_state_nxt = S_CALC;
            end
            S_CALC: begin
                mul_busy = 1'b1;
                if (mul_count == 6'(MUL_CYCLES - 1)) mul_state_nxt = S_DONE;
            end
            S_DONE: if (EX_stall_en) mul_state_nxt = S_IDLE;
            default: mul_state_nxt = S_IDLE;
        endcase
        if (!EX_rst_n) begin
            mul_state_nxt = S_IDLE;
            mul_busy      = 1'b0;
            mul_start     = 1'b0;
        end
    end

    // Shift-add datapath on unsigned magnitudes; sign applied at the end
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            mul_mcand <= '0;
            mul_mplr  <= '0;
            mul_prod  <= '0;
            mul_count <= '0;
            mul_neg   <= 1'b0;
            mul_hi    <= 1'b0;
        end else if (mul_start) begin
            mul_mcand <= {32'd0, mag_a};
            mul_mplr  <= mag_b;
            mul_prod  <= '0;
            mul_count <= '0;
            mul_neg   <= a_neg ^ b_neg;
            mul_hi    <= (EX_alu_op != 4'd11);
        end else if (mul_state == S_CALC) begin
            if (mul_mplr[0]) mul_prod <= mul_prod + mul_mcand;
            mul_mcand <= mul_mcand << 1;
            mul_mplr  <= mul_mplr >> 1;
            mul_count <= mul_count + 6'd1;
        end
    end

    assign EX_busy = mul_busy;

    // Result mux: product only once DONE, JALR target bit 0 cleared
    always_comb begin
        ex_res = alu_res;
        if (is_mul_op) ex_res = (mul_state == S_DONE) ? mul_res : '0;
        if (EX_jmp_en && !EX_opa_sel) ex_res[0] = 1'b0;
    end
`else
    assign EX_busy = 1'b0;

    // Result mux: JALR target bit 0 cleared
    always_comb begin
        ex_res = alu_res;
        if (EX_jmp_en && !EX_opa_sel) ex_res[0] = 1'b0;
    end
`endif

    // EX/MEM register: flush and multiply bubbles both load zeros
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            MEM_alu_data <= '0;
            MEM_rs2_data <= '0;
            MEM_pc_four  <= '0;
            MEM_rd_addr  <= '0;
            MEM_rd_wren  <= 1'b0;
            MEM_mem_en   <= '0;
            MEM_wb_en    <= '0;
            MEM_ld_en    <= 1'b0;
            MEM_pc_br    <= 1'b0;
        end else if (!EX_rst_n || EX_busy) begin
            MEM_alu_data <= '0;
            MEM_rs2_data <= '0;
            MEM_pc_four  <= '0;
            MEM_rd_addr  <= '0;
            MEM_rd_wren  <= 1'b0;
            MEM_mem_en   <= '0;
            MEM_wb_en    <= '0;
            MEM_ld_en    <= 1'b0;
            MEM_pc_br    <= 1'b0;
        end else if (EX_stall_en) begin
            MEM_alu_data <= ex_res;
            MEM_rs2_data <= fwd_b;
            MEM_pc_four  <= EX_pc + 32'd4;
            MEM_rd_addr  <= EX_rd_addr;
            MEM_rd_wren  <= EX_rd_wren;
            MEM_mem_en   <= EX_mem_en;
            MEM_wb_en    <= EX_wb_en;
            MEM_ld_en    <= EX_ld_en;
            MEM_pc_br    <= (EX_br_en && br_taken) || EX_jmp_en;
        end
    end

endmodule

// File: tb/tb_ex_cycle.sv
// Testbench for ex_cycle: random + directed stimulus, expected EX/MEM contents
// pushed into a queue by the driver and checked by an independent monitor.
// Multiply scenarios are included when EX_MUL_EN is defined.
module tb_ex_cycle;

    localparam int MC = 32;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        stall_en, ex_rst_n;
    logic [31:0] pc, rs1, rs2, imm, wb_fwd;
    logic [4:0]  rd;
    logic [1:0]  fwd_a, fwd_b;
    logic        opa_sel, opb_sel;
    logic [3:0]  alu_op;
    logic        br_en, jmp_en;
    logic [2:0]  br_type;
    logic        rd_wren, ld_en;
    logic [8:0]  mem_en;
    logic [1:0]  wb_en;

    logic [31:0] mem_alu, mem_rs2, mem_pc4;
    logic [4:0]  mem_rd;
    logic        mem_wren, mem_ld, mem_br, busy;
    logic [8:0]  mem_mem;
    logic [1:0]  mem_wb;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [31:0] alu, rs2, pc4;
        logic [4:0]  rd;
        logic        wren;
        logic [8:0]  mem_en;
        logic [1:0]  wb_en;
        logic        ld_en, pc_br, busy, busy_chk;
    } exp_t;

    exp_t cur;
    exp_t q[$];

    ex_cycle #(.MUL_CYCLES(MC)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .EX_stall_en(stall_en), .EX_rst_n(ex_rst_n),
        .EX_pc(pc), .EX_rs1_data(rs1), .EX_rs2_data(rs2), .EX_imm(imm),
        .EX_rd_addr(rd), .EX_fwd_a_sel(fwd_a), .EX_fwd_b_sel(fwd_b),
        .WB_fwd_data(wb_fwd), .EX_opa_sel(opa_sel), .EX_opb_sel(opb_sel),
        .EX_alu_op(alu_op), .EX_br_en(br_en), .EX_br_type(br_type),
        .EX_jmp_en(jmp_en), .EX_rd_wren(rd_wren), .EX_mem_en(mem_en),
        .EX_wb_en(wb_en), .EX_ld_en(ld_en),
        .MEM_alu_data(mem_alu), .MEM_rs2_data(mem_rs2), .MEM_pc_four(mem_pc4),
        .MEM_rd_addr(mem_rd), .MEM_rd_wren(mem_wren), .MEM_mem_en(mem_mem),
        .MEM_wb_en(mem_wb), .MEM_ld_en(mem_ld), .MEM_pc_br(mem_br), .EX_busy(busy)
    );

    always #5 clk_i = ~clk_i;

    // ---------------- reference model ----------------
    function automatic logic [31:0] alu_ref(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] p;
        case (op)
            4'd0:  return a + b;
            4'd1:  return a - b;
            4'd2:  return a << b[4:0];
            4'd3:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            4'd4:  return (a < b) ? 32'd1 : 32'd0;
            4'd5:  return a ^ b;
            4'd6:  return a >> b[4:0];
            4'd7:  begin p = {{32{a[31]}}, a} >> b[4:0]; return p[31:0]; end
            4'd8:  return a | b;
            4'd9:  return a & b;
            4'd10: return b;
`ifdef EX_MUL_EN
            4'd11: begin p = longint'($signed(a)) * longint'($signed(b)); return p[31:0]; end
            4'd12: begin p = longint'($signed(a)) * longint'($signed(b)); return p[63:32]; end
            4'd13: begin p = longint'($signed(a)) * longint'({32'd0, b}); return p[63:32]; end
            4'd14: begin p = {32'd0, a} * {32'd0, b}; return p[63:32]; end
`endif
            default: return 32'd0;
        endcase
    endfunction

    function automatic logic br_ref(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        case (f3)
            3'b000: return a == b;
            3'b001: return a != b;
            3'b100: return $signed(a) < $signed(b);
            3'b101: return !($signed(a) < $signed(b));
            3'b110: return a < b;
            3'b111: return !(a < b);
            default: return 1'b0;
        endcase
    endfunction

    function automatic exp_t zero_rec(input logic bz);
        exp_t e;
        e.alu = 0; e.rs2 = 0; e.pc4 = 0; e.rd = 0; e.wren = 0; e.mem_en = 0;
        e.wb_en = 0; e.ld_en = 0; e.pc_br = 0; e.busy = bz; e.busy_chk = 1'b1;
        return e;
    endfunction

    function automatic exp_t model_capture();
        logic [31:0] fa, fb, a, b, r;
        exp_t e;
        fa = (fwd_a == 2'b01) ? cur.alu : (fwd_a == 2'b10) ? wb_fwd : rs1;
        fb = (fwd_b == 2'b01) ? cur.alu : (fwd_b == 2'b10) ? wb_fwd : rs2;
        a  = opa_sel ? pc : fa;
        b  = opb_sel ? imm : fb;
        r  = alu_ref(alu_op, a, b);
        if (jmp_en && !opa_sel) r = r & ~32'd1;
        e.alu = r; e.rs2 = fb; e.pc4 = pc + 32'd4; e.rd = rd; e.wren = rd_wren;
        e.mem_en = mem_en; e.wb_en = wb_en; e.ld_en = ld_en;
        e.pc_br = (br_en && br_ref(br_type, fa, fb)) || jmp_en;
        e.busy = 1'b0; e.busy_chk = 1'b1;
        return e;
    endfunction

    // ---------------- stimulus helpers ----------------
    // Called at a negedge with inputs set; DUT captures them at the next posedge.
    task automatic issue();
        if (!ex_rst_n)     cur = zero_rec(1'b0);
        else if (stall_en) cur = model_capture();
        q.push_back(cur);
        @(negedge clk_i);
    endtask

    function automatic logic [31:0] rval();
        case ($urandom_range(0, 7))
            0: return 32'd0;
            1: return 32'd1;
            2: return 32'hFFFF_FFFF;
            3: return 32'h8000_0000;
            4: return $urandom_range(0, 7);
            default: return $urandom;
        endcase
    endfunction

    task automatic rand_ctrl();
        rd = 5'($urandom); rd_wren = 1'($urandom); mem_en = 9'($urandom);
        wb_en = 2'($urandom); ld_en = 1'($urandom);
    endtask

    task automatic rand_inputs();
        pc = $urandom & ~32'd3; rs1 = rval(); rs2 = rval(); imm = rval(); wb_fwd = rval();
        fwd_a = 2'($urandom); fwd_b = 2'($urandom);
        opa_sel = 1'($urandom); opb_sel = 1'($urandom);
        alu_op = 4'($urandom);
`ifdef EX_MUL_EN
        if (alu_op >= 4'd11 && alu_op <= 4'd14) alu_op = 4'd15;
`endif
        br_en = 1'($urandom); br_type = 3'($urandom);
        jmp_en = ($urandom_range(0, 7) == 0);
        stall_en = ($urandom_range(0, 99) < 85);
        ex_rst_n = ($urandom_range(0, 99) < 95);
        rand_ctrl();
    endtask

    task automatic set_basic(input logic [3:0] op);
        fwd_a = 2'b00; fwd_b = 2'b00; opa_sel = 1'b0; opb_sel = 1'b0; alu_op = op;
        br_en = 1'b0; br_type = 3'b000; jmp_en = 1'b0; stall_en = 1'b1; ex_rst_n = 1'b1;
        rd = 5'd7; rd_wren = 1'b1; mem_en = 9'h155; wb_en = 2'b10; ld_en = 1'b1;
    endtask

    task automatic check_zero(input string tag);
        checks++;
        if (mem_alu !== 0 || mem_rs2 !== 0 || mem_pc4 !== 0 || mem_rd !== 0 || mem_wren !== 0 ||
            mem_mem !== 0 || mem_wb !== 0 || mem_ld !== 0 || mem_br !== 0 || busy !== 0) begin
            errors++;
            $display("FAIL %s: actual alu=%h rs2=%h pc4=%h rd=%0d wren=%b mem=%h wb=%b ld=%b br=%b busy=%b, required all 0",
                     tag, mem_alu, mem_rs2, mem_pc4, mem_rd, mem_wren, mem_mem, mem_wb, mem_ld, mem_br, busy);
        end
    endtask

    // Asynchronous reset between edges; outputs must clear without a clock.
    task automatic reset_check(input string tag);
        @(posedge clk_i);
        #2;
        rst_ni = 1'b0;
        #1;
        check_zero(tag);
        set_basic(4'd0);
        @(negedge clk_i);
        rst_ni = 1'b1;
        cur = zero_rec(1'b0);
    endtask

`ifdef EX_MUL_EN
    task automatic run_mul(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        set_basic(op);
        pc = $urandom & ~32'd3; rs1 = a; rs2 = b; imm = $urandom; wb_fwd = $urandom;
        for (int i = 0; i < MC; i++) begin
            cur = zero_rec(1'b1);
            q.push_back(cur);
            @(negedge clk_i);
        end
        cur = zero_rec(1'b0);
        q.push_back(cur);
        @(negedge clk_i);
        cur = model_capture();
        cur.busy_chk = 1'b0;
        q.push_back(cur);
        @(negedge clk_i);
    endtask
`endif

    // ---------------- monitor ----------------
    initial begin
        exp_t e;
        forever begin
            @(posedge clk_i);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                checks++;
                if ({mem_alu, mem_rs2, mem_pc4, mem_rd, mem_wren, mem_mem, mem_wb, mem_ld, mem_br} !==
                    {e.alu, e.rs2, e.pc4, e.rd, e.wren, e.mem_en, e.wb_en, e.ld_en, e.pc_br} ||
                    (e.busy_chk && busy !== e.busy)) begin
                    errors++;
                    $display("FAIL ex_out t=%0t alu=%h/%h rs2=%h/%h pc4=%h/%h rd=%0d/%0d wren=%b/%b mem=%h/%h wb=%b/%b ld=%b/%b br=%b/%b busy=%b/%b (actual/required)",
                             $time, mem_alu, e.alu, mem_rs2, e.rs2, mem_pc4, e.pc4, mem_rd, e.rd,
                             mem_wren, e.wren, mem_mem, e.mem_en, mem_wb, e.wb_en, mem_ld, e.ld_en,
                             mem_br, e.pc_br, busy, e.busy);
                end
            end
        end
    end

    // ---------------- watchdog ----------------
    initial begin
        #500000;
        $display("FAIL watchdog: actual still running, required finished");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
        $fatal(1);
    end

    // ---------------- driver ----------------
    initial begin
        rst_ni = 1'b0;
        pc = 0; rs1 = 0; rs2 = 0; imm = 0; wb_fwd = 0;
        set_basic(4'd0);
        cur = zero_rec(1'b0);
        #12;
        check_zero("reset");
        @(negedge clk_i);
        rst_ni = 1'b1;

        // forwarding from MEM_alu_data
        set_basic(4'd10); opb_sel = 1'b1; imm = 32'd7; pc = 32'h100;
        issue();
        set_basic(4'd0); rs1 = 32'd5; fwd_a = 2'b01; opb_sel = 1'b1; imm = 32'd3;
        issue();
        // WB forwarding on B, store data path
        set_basic(4'd1); rs1 = 32'd20; fwd_b = 2'b10; wb_fwd = 32'd6; rs2 = 32'd99;
        issue();

        // BLT taken, BLTU not taken with the same operands
        set_basic(4'd0); rs1 = 32'hFFFF_FFFF; rs2 = 32'd1; opa_sel = 1'b1; opb_sel = 1'b1;
        pc = 32'h1000; imm = 32'h40; br_en = 1'b1; br_type = 3'b100;
        issue();
        br_type = 3'b110;
        issue();

        // JALR clears bit 0; PC+4 wraps at the top of the address space
        set_basic(4'd0); rs1 = 32'h101; imm = 32'd0; opb_sel = 1'b1; jmp_en = 1'b1; pc = 32'h2000;
        issue();
        pc = 32'hFFFF_FFFC;
        issue();

        // hold three clocks with changing inputs, then flush
        for (int i = 0; i < 3; i++) begin
            rand_inputs();
            stall_en = 1'b0; ex_rst_n = 1'b1;
            issue();
        end
        rand_inputs();
        ex_rst_n = 1'b0;
        issue();

        for (int i = 0; i < 400; i++) begin
            rand_inputs();
            issue();
        end

        reset_check("reset_mid_run");
        for (int i = 0; i < 5; i++) begin
            rand_inputs();
            issue();
        end

`ifdef EX_MUL_EN
        run_mul(4'd12, 32'hFFFF_FFFD, 32'd5);
        run_mul(4'd11, 32'hFFFF_FFFD, 32'd5);
        for (int i = 0; i < 8; i++) begin
            run_mul(4'($urandom_range(11, 14)), rval(), rval());
            rand_inputs();
            issue();
        end
        // reset during CALC
        set_basic(4'd12); rs1 = 32'd9; rs2 = 32'd9;
        for (int i = 0; i < 5; i++) begin
            cur = zero_rec(1'b1);
            q.push_back(cur);
            @(negedge clk_i);
        end
        reset_check("reset_mid_mul");
        for (int i = 0; i < 5; i++) begin
            rand_inputs();
            issue();
        end
`endif

        repeat (3) @(negedge clk_i);
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain: actual %0d pending, required 0", q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
